// File: rtl/sr_meas_ctrl.sv
// rtl/sr_meas_ctrl.sv - ultrasonic ranging sensor trigger/echo measurement controller
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   start     single-measurement request (honoured in IDLE only)
//   cont      continuous mode: re-trigger after every holdoff while high
//   sr_echo   sensor echo, asynchronous to clk
//   sr_trig   sensor trigger pulse, TRIG_CYCLES wide
//   meas_en   high while an echo is being timed
//   busy      high in every state except IDLE
//   dist_cnt  last valid echo width in clk cycles
//   valid     one-cycle strobe, dist_cnt updated
//   timeout   one-cycle strobe, measurement aborted
module sr_meas_ctrl #(
    parameter int TRIG_CYCLES    = 10,
    parameter int TIMEOUT_CYCLES = 38000,
    parameter int HOLDOFF_CYCLES = 60000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cont,
    input  logic             sr_echo,
    output logic             sr_trig,
    output logic             meas_en,
    output logic             busy,
    output logic [CNT_W-1:0] dist_cnt,
    output logic             valid,
    output logic             timeout
);

    // Terminal counts: each phase ends on the cycle that would make the
    // counter reach its limit, so the phase lasts exactly that many cycles.
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        HOLDOFF
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             echo_meta;
    logic             echo_s;
    logic             echo_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
            echo_prev <= 1'b0;
        end else begin
            echo_meta <= sr_echo;
            echo_s    <= echo_meta;
            echo_prev <= echo_s;
        end
    end

    // Outputs are assigned together with the state they belong to, so each
    // one is a flop that already reflects the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            sr_trig  <= 1'b0;
            meas_en  <= 1'b0;
            busy     <= 1'b0;
            dist_cnt <= '0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            valid   <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (start || cont) begin
                        state   <= TRIG;
                        cnt     <= '0;
                        sr_trig <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                TRIG: begin
                    if (cnt == TRIG_LAST) begin
                        state   <= WAIT_ECHO;
                        cnt     <= '0;
                        sr_trig <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                WAIT_ECHO: begin
                    // Only a genuine 0->1 transition counts; an echo that is
                    // already high on entry has echo_prev=1 and is ignored.
                    if (echo_s && !echo_prev) begin
                        state   <= MEASURE;
                        cnt     <= CNT_ONE;
                        meas_en <= 1'b1;
                    end else if (cnt == TO_LAST) begin
                        state   <= HOLDOFF;
                        cnt     <= '0;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                MEASURE: begin
                    // cnt holds the number of high samples seen so far.
                    if (!echo_s) begin
                        state    <= HOLDOFF;
                        cnt      <= '0;
                        meas_en  <= 1'b0;
                        dist_cnt <= cnt;
                        valid    <= 1'b1;
                    end else if (cnt == TO_LAST) begin
                        state   <= HOLDOFF;
                        cnt     <= '0;
                        meas_en <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HOLDOFF: begin
                    if (cnt == HOLD_LAST) begin
                        cnt <= '0;
                        if (cont) begin
                            state   <= TRIG;
                            sr_trig <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    sr_trig <= 1'b0;
                    meas_en <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_meas_ctrl.sv
// tb/tb_sr_meas_ctrl.sv - self-checking bench for sr_meas_ctrl
module tb_sr_meas_ctrl;

    localparam int TRIG_CYCLES    = 4;
    localparam int TIMEOUT_CYCLES = 50;
    localparam int HOLDOFF_CYCLES = 8;
    localparam int CNT_W          = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             cont;
    logic             sr_echo;
    logic             sr_trig;
    logic             meas_en;
    logic             busy;
    logic [CNT_W-1:0] dist_cnt;
    logic             valid;
    logic             timeout;

    sr_meas_ctrl #(
        .TRIG_CYCLES   (TRIG_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .cont    (cont),
        .sr_echo (sr_echo),
        .sr_trig (sr_trig),
        .meas_en (meas_en),
        .busy    (busy),
        .dist_cnt(dist_cnt),
        .valid   (valid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int n_trig, n_meas, n_valid, n_to, n_overlap;
    int strobe_cyc, busy_fall_cyc, trig_fall_cyc, trig_rise_cyc;
    logic prev_busy = 1'b0;
    logic prev_trig = 1'b0;

    typedef struct {
        int delay;
        int width;
        int e_valid;
        int e_to;
        int e_dist;
        int e_meas;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        n_trig = 0; n_meas = 0; n_valid = 0; n_to = 0; n_overlap = 0;
        strobe_cyc = -1; busy_fall_cyc = -1; trig_fall_cyc = -1; trig_rise_cyc = -1;
    endtask

    // Advance one clock and sample all outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (sr_trig) n_trig++;
        if (meas_en) n_meas++;
        if (valid) begin
            n_valid++;
            strobe_cyc = cyc;
        end
        if (timeout) begin
            n_to++;
            strobe_cyc = cyc;
        end
        if (valid && timeout) n_overlap++;
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        if (prev_trig && !sr_trig) trig_fall_cyc = cyc;
        if (!prev_trig && sr_trig) trig_rise_cyc = cyc;
        prev_busy = busy;
        prev_trig = sr_trig;
    endtask

    task automatic wait_trig_low(input string name);
        int g = 0;
        while (sr_trig && g < 100) begin
            tick();
            g++;
        end
        chk({name, "_trig_end"}, int'(sr_trig), 0);
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        while (busy && g < 400) begin
            tick();
            g++;
        end
        chk({name, "_idle"}, int'(busy), 0);
    endtask

    task automatic echo_pulse(input int width);
        sr_echo = 1'b1;
        for (int i = 0; i < width; i++) tick();
        sr_echo = 1'b0;
    endtask

    initial begin
        vecs[0] = '{delay: 5, width: 20,  e_valid: 1, e_to: 0, e_dist: 20, e_meas: 20};
        vecs[1] = '{delay: 2, width: 1,   e_valid: 1, e_to: 0, e_dist: 1,  e_meas: 1};
        vecs[2] = '{delay: 0, width: 49,  e_valid: 1, e_to: 0, e_dist: 49, e_meas: 49};
        vecs[3] = '{delay: 3, width: 50,  e_valid: 0, e_to: 1, e_dist: 49, e_meas: 49};
        vecs[4] = '{delay: 0, width: 0,   e_valid: 0, e_to: 1, e_dist: 49, e_meas: 0};
        vecs[5] = '{delay: 1, width: 100, e_valid: 0, e_to: 1, e_dist: 49, e_meas: 49};

        reset = 1'b1; start = 1'b0; cont = 1'b0; sr_echo = 1'b0;
        clear_stats();
        #12;
        chk("rst_trig", int'(sr_trig), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_meas", int'(meas_en), 0);
        chk("rst_dist", int'(dist_cnt), 0);
        chk("rst_strobes", int'(valid) + int'(timeout), 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("idle_no_start", int'(busy), 0);

        // Single-shot vectors
        foreach (vecs[k]) begin
            clear_stats();
            start = 1'b1;
            tick();
            start = 1'b0;
            wait_trig_low($sformatf("v%0d", k));
            for (int i = 0; i < vecs[k].delay; i++) tick();
            echo_pulse(vecs[k].width);
            wait_idle($sformatf("v%0d", k));
            chk($sformatf("v%0d_trig_len", k), n_trig, TRIG_CYCLES);
            chk($sformatf("v%0d_valid", k), n_valid, vecs[k].e_valid);
            chk($sformatf("v%0d_timeout", k), n_to, vecs[k].e_to);
            chk($sformatf("v%0d_dist", k), int'(dist_cnt), vecs[k].e_dist);
            chk($sformatf("v%0d_meas_len", k), n_meas, vecs[k].e_meas);
            chk($sformatf("v%0d_holdoff", k), busy_fall_cyc - strobe_cyc, HOLDOFF_CYCLES);
            if (vecs[k].width == 0)
                chk($sformatf("v%0d_to_latency", k), strobe_cyc - trig_fall_cyc, TIMEOUT_CYCLES);
            chk($sformatf("v%0d_overlap", k), n_overlap, 0);
        end

        // Continuous mode: echo 10 then 30, CONT dropped during the second echo
        clear_stats();
        cont = 1'b1;
        tick();
        wait_trig_low("c1");
        for (int i = 0; i < 3; i++) tick();
        echo_pulse(10);
        for (int g = 0; g < 100 && n_valid == 0; g++) tick();
        chk("c1_valid", n_valid, 1);
        chk("c1_dist", int'(dist_cnt), 10);
        for (int g = 0; g < 100 && trig_rise_cyc <= strobe_cyc; g++) tick();
        chk("c_retrig_gap", trig_rise_cyc - strobe_cyc, HOLDOFF_CYCLES);
        wait_trig_low("c2");
        for (int i = 0; i < 2; i++) tick();
        sr_echo = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        cont = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        sr_echo = 1'b0;
        wait_idle("c2");
        chk("c2_valid", n_valid, 2);
        chk("c2_dist", int'(dist_cnt), 30);
        chk("c2_holdoff", busy_fall_cyc - strobe_cyc, HOLDOFF_CYCLES);
        chk("c_trig_total", n_trig, 2 * TRIG_CYCLES);
        for (int i = 0; i < 20; i++) tick();
        chk("c_stays_idle", int'(busy) + n_trig - 2 * TRIG_CYCLES, 0);

        // Echo high on WAIT_ECHO entry, extra START while busy
        clear_stats();
        sr_echo = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_trig_low("h");
        for (int i = 0; i < 5; i++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("h_no_meas_yet", n_meas + n_valid + n_to, 0);
        sr_echo = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        echo_pulse(15);
        wait_idle("h");
        chk("h_valid", n_valid, 1);
        chk("h_dist", int'(dist_cnt), 15);
        for (int i = 0; i < 15; i++) tick();
        chk("h_start_not_queued", int'(busy) + n_trig, TRIG_CYCLES);

        // Reset during MEASURE with echo high
        clear_stats();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_trig_low("r");
        sr_echo = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("r_in_measure", int'(meas_en), 1);
        reset = 1'b1;
        #1;
        chk("r_async_outputs",
            int'(sr_trig) + int'(meas_en) + int'(busy) + int'(valid) + int'(timeout), 0);
        chk("r_async_dist", int'(dist_cnt), 0);
        n_valid = 0; n_to = 0; n_meas = 0;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        sr_echo = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("r_no_strobes", n_valid + n_to + n_meas, 0);
        chk("r_idle_after", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sr_meas_ctrl.md
SR_MEAS_CTRL -- requirements
Module: sr_meas_ctrl

Interface
REQ-001 SHALL have parameter TRIG_CYCLES, default 10: trigger pulse width in CLK cycles.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 38000: maximum wait or echo width in CLK cycles.
REQ-003 SHALL have parameter HOLDOFF_CYCLES, default 60000: dead time between measurements in CLK cycles.
REQ-004 SHALL have parameter CNT_W, default 16: counter and result width; TIMEOUT_CYCLES and HOLDOFF_CYCLES SHALL fit in CNT_W.
REQ-005 CLK  input  1  single system clock, rising edge.
REQ-006 RESET  input  1  asynchronous, active-high reset.
REQ-007 START  input  1  single-measurement request, sampled in IDLE only.
REQ-008 CONT  input  1  continuous mode: re-trigger after each holdoff while high.
REQ-009 SR_ECHO  input  1  sensor echo, asynchronous to CLK.
REQ-010 SR_TRIG  output  1  sensor trigger pulse.
REQ-011 MEAS_EN  output  1  high while an echo is being timed (state MEASURE).
REQ-012 BUSY  output  1  high in every state except IDLE.
REQ-013 DIST_CNT  output  CNT_W  last valid echo width in CLK cycles.
REQ-014 VALID  output  1  one-cycle strobe: DIST_CNT updated.
REQ-015 TIMEOUT  output  1  one-cycle strobe: measurement aborted.

Function
REQ-016 SR_ECHO SHALL pass through a 2-flop synchronizer (echo_s); all decisions SHALL use echo_s and its previous value only.
REQ-017 FSM states SHALL be IDLE, TRIG, WAIT_ECHO, MEASURE and HOLDOFF, with one shared CNT_W-bit cycle counter.
REQ-018 IDLE: if START or CONT is high, SHALL go to TRIG with the counter cleared; otherwise SHALL stay in IDLE.
REQ-019 TRIG: SR_TRIG SHALL be high for exactly TRIG_CYCLES cycles, then the FSM SHALL go to WAIT_ECHO with the counter cleared.
REQ-020 WAIT_ECHO: a rising edge of echo_s (previous 0, current 1) SHALL move to MEASURE with the counter set to 1.
REQ-021 WAIT_ECHO: echo_s already high on entry SHALL NOT count as an edge; a low sample is required first.
REQ-022 WAIT_ECHO: if the counter reaches TIMEOUT_CYCLES with no edge, SHALL pulse TIMEOUT for 1 cycle and go to HOLDOFF.
REQ-023 MEASURE: each cycle with echo_s=1 SHALL increment the counter.
REQ-024 MEASURE: on the first cycle with echo_s=0, SHALL load DIST_CNT with the counter, pulse VALID in the same cycle the register loads, and go to HOLDOFF.
REQ-025 MEASURE: if the counter reaches TIMEOUT_CYCLES with echo_s still 1, SHALL pulse TIMEOUT, leave DIST_CNT unchanged and go to HOLDOFF.
REQ-026 An echo N cycles wide (after sync) SHALL yield DIST_CNT=N, for 1<=N<TIMEOUT_CYCLES.
REQ-027 HOLDOFF: SHALL wait HOLDOFF_CYCLES cycles, then go to TRIG if CONT=1, otherwise to IDLE.
REQ-028 HOLDOFF exit SHALL ignore echo activity; a new measurement SHALL never start before HOLDOFF completes.
REQ-029 START outside IDLE SHALL be ignored and not queued; START and CONT together SHALL behave as CONT.
REQ-030 Dropping CONT mid-measurement SHALL finish the current cycle and return to IDLE after HOLDOFF.
REQ-031 VALID and TIMEOUT SHALL never be high in the same cycle.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 RESET high SHALL immediately force: state IDLE, counter 0, synchronizer flops 0, SR_TRIG=0, MEAS_EN=0, BUSY=0, DIST_CNT=0, VALID=0, TIMEOUT=0.
REQ-034 RESET asserted mid-operation SHALL abort without a VALID or TIMEOUT strobe; operation SHALL resume only on START or CONT after RESET falls.

Verification
REQ-035 Bench SHALL use TRIG_CYCLES=4, TIMEOUT_CYCLES=50, HOLDOFF_CYCLES=8, CNT_W=16.
REQ-036 Single shot: START 1-cycle pulse; echo high 20 cycles, 5 cycles after trigger ends -> SR_TRIG high exactly 4 cycles; MEAS_EN high 20 cycles; DIST_CNT=20 with VALID 1 cycle; BUSY low 8 cycles after VALID.
REQ-037 No echo: START, SR_ECHO held 0 -> TIMEOUT strobe 50 cycles after WAIT_ECHO entry; DIST_CNT keeps its prior value; no VALID.
REQ-038 Stuck echo: SR_ECHO high 100 cycles after a low sample -> TIMEOUT when the counter reaches 50; MEAS_EN falls; no VALID.
REQ-039 Continuous: CONT=1, echo widths 10 then 30 -> two triggers 8 holdoff cycles apart; DIST_CNT=10, then 30; CONT=0 -> IDLE after the next holdoff.
REQ-040 Echo high at WAIT_ECHO entry and START during BUSY -> no measurement until echo goes low then high; extra START has no effect.
REQ-041 RESET during MEASURE (echo high) -> all outputs 0 within the same cycle; no strobes; IDLE after RESET release.
